lsu: RTL and testbench

Load/store unit for the MEM stage of the pipelined RV32I core, fed directly by the EX/MEM pipeline register and feeding the MEM/WB register. It turns each load or store into a valid/ready request on the data-memory port, with the store data placed in its byte lanes and byte strobes set. It stalls the whole pipeline until the access completes. Load data is returned to writeback already shifted into position and sign- or zero-extended per funct3.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_align.sv | 80 ++++++++
 rtl/lsu.sv | 158 +++++++++++++++
 tb/tb_lsu.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: state, access-size and funct3 definitions for the MEM-stage LSU.
// Misaligned-access trapping is built in when LSU_MISALIGN_CHECK_EN is defined.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // Stores only know sb/sh; every other store code is a full word.
    function automatic lsu_size_e access_size(
        input logic [2:0] funct3,
        input logic       is_store
    );
        lsu_size_e sz;
        sz = SZ_W;
        if (is_store) begin
            if (funct3 == F3_B)
                sz = SZ_B;
            else if (funct3 == F3_H)
                sz = SZ_H;
        end else begin
            case (funct3)
                F3_B, F3_BU: sz = SZ_B;
                F3_H, F3_HU: sz = SZ_H;
                default:     sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(
        input lsu_size_e  sz,
        input logic [1:0] off
    );
        return ((sz == SZ_H) && off[0]) ||
               ((sz == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational store lane replication/strobes and
// load shift plus sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_st_funct3,
    input  logic [1:0]            i_st_off,
    input  logic [DATA_WIDTH-1:0] i_st_data,
    output logic [3:0]            o_st_be,
    output logic [DATA_WIDTH-1:0] o_st_wdata,
    input  logic [2:0]            i_ld_funct3,
    input  logic [1:0]            i_ld_off,
    input  logic [DATA_WIDTH-1:0] i_ld_word,
    output logic [DATA_WIDTH-1:0] o_ld_data
);

    lsu_size_e             w_st_size;
    lsu_size_e             w_ld_size;
    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_st_size = access_size(i_st_funct3, 1'b1);
    assign w_ld_size = access_size(i_ld_funct3, 1'b0);

    // Store: replicate the datum into every lane it could land in.
    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
        case (w_st_size)
            SZ_B: begin
                o_st_be    = 4'b0001 << i_st_off;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_st_be    = 4'b0011 << {i_st_off[1], 1'b0};
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_data;
            end
        endcase
    end

    // Load: halfwords use lane off[1], words use the containing word.
    always_comb begin
        w_shamt = 5'd0;
        case (w_ld_size)
            SZ_B:    w_shamt = {i_ld_off, 3'b000};
            SZ_H:    w_shamt = {i_ld_off[1], 4'b0000};
            default: w_shamt = 5'd0;
        endcase
    end

    assign w_shifted = i_ld_word >> w_shamt;

    // Extend the shifted datum according to funct3.
    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_funct3)
            F3_B:
                o_ld_data = {{(DATA_WIDTH-8){w_shifted[7]}},
                             w_shifted[7:0]};
            F3_H:
                o_ld_data = {{(DATA_WIDTH-16){w_shifted[15]}},
                             w_shifted[15:0]};
            F3_BU:
                o_ld_data = {{(DATA_WIDTH-8){1'b0}},
                             w_shifted[7:0]};
            F3_HU:
                o_ld_data = {{(DATA_WIDTH-16){1'b0}},
                             w_shifted[15:0]};
            default:
                o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit; valid/ready data-memory master that
// stalls the pipeline per access. Optional trap: LSU_MISALIGN_CHECK_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memwrite_m,
    input  logic [1:0]            resultsrc_m,
    input  logic [2:0]            funct3_m,
    input  logic [DATA_WIDTH-1:0] aluresult_m,
    input  logic [DATA_WIDTH-1:0] writedata_m,
    output logic                  stall_m,
    output logic [DATA_WIDTH-1:0] readdata_m,
    output logic                  misalign_m,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_be,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

    lsu_state_e            r_state;
    lsu_state_e            w_state_nxt;
    logic                  w_access;
    logic                  w_mis;
    logic                  w_launch;
    logic                  w_mis_done;
    logic                  w_stall;
    logic                  w_req_valid;
    logic [3:0]            w_st_be;
    logic [DATA_WIDTH-1:0] w_st_wdata;
    logic [DATA_WIDTH-1:0] w_ld_data;

    logic                  r_req_we;
    logic [DATA_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic [3:0]            r_req_be;
    logic [2:0]            r_ld_funct3;
    logic [1:0]            r_ld_off;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_misalign;

    assign w_access = memwrite_m | (resultsrc_m == RESULTSRC_LOAD);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_mis = is_misaligned(access_size(funct3_m, memwrite_m),
                                 aluresult_m[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    assign w_launch   = (r_state == IDLE) & w_access & ~w_mis;
    assign w_mis_done = (r_state == IDLE) & w_access & w_mis;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_st_funct3 (funct3_m),
        .i_st_off    (aluresult_m[1:0]),
        .i_st_data   (writedata_m),
        .o_st_be     (w_st_be),
        .o_st_wdata  (w_st_wdata),
        .i_ld_funct3 (r_ld_funct3),
        .i_ld_off    (r_ld_off),
        .i_ld_word   (mem_resp_rdata),
        .o_ld_data   (w_ld_data)
    );

    // Next-state, stall and request-valid decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_stall     = 1'b1;
                    w_state_nxt = w_mis ? DONE : REQ;
                end
            end
            REQ: begin
                w_stall     = 1'b1;
                w_req_valid = 1'b1;
                if (mem_req_ready)
                    w_state_nxt = r_req_we ? DONE : WAIT;
            end
            WAIT: begin
                w_stall = 1'b1;
                if (mem_resp_valid)
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Request fields, captured once in IDLE and held through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= 4'b0000;
            r_ld_funct3 <= 3'b000;
            r_ld_off    <= 2'b00;
        end else if (w_launch) begin
            r_req_we    <= memwrite_m;
            r_req_addr  <= {aluresult_m[DATA_WIDTH-1:2], 2'b00};
            r_req_wdata <= w_st_wdata;
            r_req_be    <= w_st_be;
            r_ld_funct3 <= funct3_m;
            r_ld_off    <= aluresult_m[1:0];
        end
    end

    // Load result register; holds between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_readdata <= '0;
        else if ((r_state == WAIT) && mem_resp_valid)
            r_readdata <= w_ld_data;
        else if (w_mis_done)
            r_readdata <= '0;
    end

    // Misalign flag is high only in the DONE cycle of a trapped access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_misalign <= 1'b0;
        else
            r_misalign <= w_mis_done;
    end

    assign stall_m       = w_stall;
    assign readdata_m    = r_readdata;
    assign misalign_m    = r_misalign;
    assign mem_req_valid = w_req_valid;
    assign mem_req_we    = r_req_we;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_be    = r_req_be;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu; byte-level reference memory,
// randomized memory latencies, directed corner cases.
module tb_lsu;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          memwrite_m;
    logic [1:0]    resultsrc_m;
    logic [2:0]    funct3_m;
    logic [DW-1:0] aluresult_m;
    logic [DW-1:0] writedata_m;
    logic          stall_m;
    logic [DW-1:0] readdata_m;
    logic          misalign_m;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [DW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic [3:0]    mem_req_be;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_rdata;

    always #5 clk = ~clk;

    lsu #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memwrite_m     (memwrite_m),
        .resultsrc_m    (resultsrc_m),
        .funct3_m       (funct3_m),
        .aluresult_m    (aluresult_m),
        .writedata_m    (writedata_m),
        .stall_m        (stall_m),
        .readdata_m     (readdata_m),
        .misalign_m     (misalign_m),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_be     (mem_req_be),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
    } req_t;

    typedef struct {
        bit        is_load;
        bit        chk;
        bit [31:0] data;
        bit        mis;
    } res_t;

    req_t      exp_req[$];
    res_t      exp_res[$];
    int        wq_r[$];
    int        wq_p[$];
    bit [31:0] mem[bit [31:0]];
    bit [31:0] ref_mem[bit [31:0]];
    int        n_chk = 0;
    int        n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] init_word(input bit [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic bit [31:0] mem_word(input bit [31:0] wa);
        return mem.exists(wa) ? mem[wa] : init_word(wa);
    endfunction

    function automatic bit [31:0] ref_word(input bit [31:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic bit [7:0] ref_byte(input bit [31:0] a);
        bit [31:0] w;
        w = ref_word({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    function automatic void ref_wbyte(input bit [31:0] a, input bit [7:0] b);
        bit [31:0] w;
        w = ref_word({a[31:2], 2'b00});
        w[{a[1:0], 3'b000} +: 8] = b;
        ref_mem[{a[31:2], 2'b00}] = w;
    endfunction

    function automatic void preload(input bit [31:0] wa, input bit [31:0] v);
        mem[wa]     = v;
        ref_mem[wa] = v;
    endfunction

    // Present one instruction in MEM, predict its effect, count its stalls.
    task automatic issue(input bit mw, input bit [1:0] rs, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] wd,
                         input int rw, input int pw, input bit chk = 1'b1);
        bit        st, ld, acc, mis;
        int        size, exp_stall, cnt;
        bit [31:0] wa, base, v;
        req_t      rq;
        res_t      rr;
        st  = mw;
        ld  = !mw && (rs == 2'b01);
        acc = st || ld;
        if (st)
            size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        else
            size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = ((size == 2) && addr[0]) || ((size == 4) && (addr[1:0] != 2'b00));
`endif
        wa   = {addr[31:2], 2'b00};
        base = (size == 1) ? addr : (size == 2) ? {addr[31:2], addr[1], 1'b0} : wa;
        exp_stall = !acc ? 0 : mis ? 1 : st ? 2 + rw : 3 + rw + pw;
        rq.we = st; rq.addr = wa; rq.be = 4'b0000; rq.wdata = 32'h0;
        rr.is_load = ld; rr.chk = chk; rr.data = 32'h0; rr.mis = mis;
        if (acc && mis) begin
            rr.data = 32'h0;
            exp_res.push_back(rr);
        end else if (st) begin
            for (int i = 0; i < size; i++) begin
                rq.be[int'(base[1:0]) + i] = 1'b1;
                ref_wbyte(base + i, wd[8*i +: 8]);
            end
            for (int j = 0; j < 4; j++)
                rq.wdata[8*j +: 8] = wd[8*(j % size) +: 8];
            exp_req.push_back(rq);
            exp_res.push_back(rr);
            wq_r.push_back(rw);
            wq_p.push_back(pw);
        end else if (ld) begin
            v = 32'h0;
            for (int i = 0; i < size; i++)
                v |= 32'(ref_byte(base + i)) << (8 * i);
            if (size == 1 && !f3[2] && v[7])
                v |= 32'hFFFFFF00;
            if (size == 2 && !f3[2] && v[15])
                v |= 32'hFFFF0000;
            rr.data = v;
            exp_req.push_back(rq);
            exp_res.push_back(rr);
            wq_r.push_back(rw);
            wq_p.push_back(pw);
        end
        memwrite_m  = mw;
        resultsrc_m = rs;
        funct3_m    = f3;
        aluresult_m = addr;
        writedata_m = wd;
        cnt = 0;
        #1;
        while (stall_m === 1'b1 && cnt < 64) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", cnt, exp_stall);
        @(negedge clk);
    endtask

    // Memory device: programmable ready/response delays, request checks.
    initial begin : responder
        req_t cap;
        req_t ex;
        int   rw, pw;
        bit   stable;
        bit [31:0] w;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_req_valid === 1'b1) begin
                rw = 0;
                pw = 0;
                if (wq_r.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    rw = wq_r.pop_front();
                    pw = wq_p.pop_front();
                end
                cap.we = mem_req_we; cap.addr = mem_req_addr;
                cap.be = mem_req_be; cap.wdata = mem_req_wdata;
                repeat (rw) begin
                    mem_req_ready = 1'b0;
                    @(negedge clk);
                    stable = mem_req_valid && (mem_req_we == cap.we) &&
                             (mem_req_addr == cap.addr) && (mem_req_be == cap.be) &&
                             (mem_req_wdata == cap.wdata);
                    check("req_stable", {31'b0, stable}, 32'd1);
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                if (exp_req.size() != 0) begin
                    ex = exp_req.pop_front();
                    check("req_we", {31'b0, cap.we}, {31'b0, ex.we});
                    check("req_addr", cap.addr, ex.addr);
                    if (ex.we) begin
                        check("req_be", {28'b0, cap.be}, {28'b0, ex.be});
                        check("req_wdata", cap.wdata, ex.wdata);
                    end
                end
                if (cap.we) begin
                    w = mem_word(cap.addr);
                    for (int i = 0; i < 4; i++)
                        if (cap.be[i])
                            w[8*i +: 8] = cap.wdata[8*i +: 8];
                    mem[cap.addr] = w;
                end else begin
                    repeat (pw) @(negedge clk);
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mem_word(cap.addr);
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                    mem_resp_rdata = $urandom;
                end
            end
        end
    end

    // Result monitor: the DONE cycle is an access with stall_m low.
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && stall_m === 1'b0 &&
                (memwrite_m === 1'b1 || resultsrc_m === 2'b01)) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = exp_res.pop_front();
                    check("misalign_m", {31'b0, misalign_m}, {31'b0, r.mis});
                    if ((r.is_load || r.mis) && r.chk)
                        check("readdata_m", readdata_m, r.data);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit [2:0]  f3;
        bit [31:0] a, d;
        int        kind, sz;
        rst_n       = 1'b0;
        memwrite_m  = 1'b0;
        resultsrc_m = 2'b00;
        funct3_m    = 3'b000;
        aluresult_m = 32'h0;
        writedata_m = 32'h0;
        #2;
        check("rst_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_we", {31'b0, mem_req_we}, 32'd0);
        check("rst_addr", mem_req_addr, 32'h0);
        check("rst_wdata", mem_req_wdata, 32'h0);
        check("rst_be", {28'b0, mem_req_be}, 32'h0);
        check("rst_readdata", readdata_m, 32'h0);
        check("rst_misalign", {31'b0, misalign_m}, 32'd0);
        check("rst_stall", {31'b0, stall_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 2'b00, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0);
        preload(32'h2000, 32'h0000_F000);
        issue(1'b0, 2'b01, 3'b000, 32'h0000_2001, 32'h0, 0, 0);
        issue(1'b0, 2'b01, 3'b100, 32'h0000_2001, 32'h0, 0, 0);
        preload(32'h2000, 32'h8001_0000);
        issue(1'b0, 2'b01, 3'b001, 32'h0000_2002, 32'h0, 3, 1);
`ifdef LSU_MISALIGN_CHECK_EN
        issue(1'b0, 2'b01, 3'b010, 32'h0000_3002, 32'h0, 0, 0);
`else
        issue(1'b0, 2'b01, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 1'b0);
`endif
        issue(1'b1, 2'b00, 3'b010, 32'h0000_3010, 32'hCAFE_F00D, 1, 0);
        issue(1'b0, 2'b01, 3'b010, 32'h0000_3010, 32'h0, 0, 2);
        issue(1'b0, 2'b00, 3'b010, 32'h0000_3010, 32'h0, 0, 0);
        issue(1'b1, 2'b01, 3'b001, 32'h0000_3012, 32'h1234_BEEF, 0, 0);
        issue(1'b0, 2'b01, 3'b101, 32'h0000_3012, 32'h0, 0, 0);
        issue(1'b0, 2'b10, 3'b000, 32'h0000_3012, 32'h0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 4);
            a    = 32'h4000 + $urandom_range(0, 63);
            d    = $urandom;
            if (kind <= 1) begin
                f3 = 3'($urandom_range(0, 3));
                sz = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
                if (sz == 2) a[0] = 1'b0;
                if (sz == 4) a[1:0] = 2'b00;
                issue(1'b1, 2'($urandom_range(0, 3)), f3, a, d,
                      $urandom_range(0, 3), 0);
            end else if (kind <= 3) begin
                f3 = 3'($urandom_range(0, 7));
                sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
                if (sz == 2) a[0] = 1'b0;
                if (sz == 4) a[1:0] = 2'b00;
                issue(1'b0, 2'b01, f3, a, d,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                issue(1'b0, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10,
                      3'($urandom_range(0, 7)), a, d, 0, 0);
            end
        end

        wq_r.push_back(0);
        wq_p.push_back(5);
        exp_req.push_back('{we: 1'b0, addr: 32'h5000, be: 4'h0, wdata: 32'h0});
        memwrite_m  = 1'b0;
        resultsrc_m = 2'b01;
        funct3_m    = 3'b010;
        aluresult_m = 32'h5000;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("wait_stall", {31'b0, stall_m}, 32'd1);
        check("wait_valid", {31'b0, mem_req_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, mem_req_valid}, 32'd0);
        check("midrst_addr", mem_req_addr, 32'h0);
        resultsrc_m = 2'b00;
        #1;
        check("midrst_stall", {31'b0, stall_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("late_resp_stall", {31'b0, stall_m}, 32'd0);
        check("late_resp_valid", {31'b0, mem_req_valid}, 32'd0);
        check("late_resp_readdata", readdata_m, 32'h0);
        check("req_queue_drained", exp_req.size(), 32'd0);
        check("res_queue_drained", exp_res.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
